// File: rtl/mmac_pkg.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | mmac_pkg                                                              |
// | Shared types and constants for the MMAC operand loader slice.         |
// | Revision: 1.0                                                         |
// +-----------------------------------------------------------------------+
package mmac_pkg;

    typedef enum logic [1:0] {
        LOAD_A  = 2'd0,
        LOAD_B  = 2'd1,
        PRESENT = 2'd2
    } loader_state_e;

    localparam int N      = 4;
    localparam int ELEM_W = 8;
    localparam int TILE_W = N * N * ELEM_W;

    // Bit offset of element [r][c] inside a packed N x N tile.
    function automatic int elem_off(input int r, input int c, input int n, input int w);
        return (r * n + c) * w;
    endfunction

endpackage
`default_nettype wire

// File: rtl/mmac_tile_reg.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | mmac_tile_reg                                                         |
// | N-row tile register written one row at a time; async active-low clear.|
// | Revision: 1.0                                                         |
// +-----------------------------------------------------------------------+
module mmac_tile_reg #(
    parameter int N      = 4,
    parameter int ELEM_W = 8,
    parameter int ROW_W  = 2
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    we,
    input  logic [ROW_W-1:0]        row,
    input  logic [N*ELEM_W-1:0]     din,
    output logic [N*N*ELEM_W-1:0]   q
);
    import mmac_pkg::*;

    generate
        for (genvar r = 0; r < N; r++) begin : g_row
            logic [N*ELEM_W-1:0] r_row;

            always_ff @(posedge clk or negedge rst) begin
                if (!rst) begin
                    r_row <= '0;
                end else if (we && (row == ROW_W'(r))) begin
                    r_row <= din;
                end
            end

            assign q[elem_off(r, 0, N, ELEM_W) +: N*ELEM_W] = r_row;
        end
    endgenerate

endmodule
`default_nettype wire

// File: rtl/mmac_operand_loader.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | mmac_operand_loader                                                   |
// | Assembles A then B tiles from row beats and presents them to the MAC. |
// | Revision: 1.0                                                         |
// +-----------------------------------------------------------------------+
module mmac_operand_loader #(
    parameter int N       = 4,
    parameter int ELEM_W  = 8,
    parameter int K_TILES = 4
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    flush,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [N*ELEM_W-1:0]     in_data,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [N*N*ELEM_W-1:0]   matrix_a,
    output logic [N*N*ELEM_W-1:0]   matrix_b,
    output logic                    out_clear,
    output logic                    out_last,
    output logic [7:0]              tile_idx
);
    import mmac_pkg::*;

    localparam int              ROW_W       = (N > 1) ? $clog2(N) : 1;
    localparam logic [ROW_W-1:0] C_ROW_LAST  = ROW_W'(N - 1);
    localparam logic [7:0]       C_TILE_LAST = 8'(K_TILES - 1);

    loader_state_e      r_state;
    loader_state_e      w_state_nxt;
    logic [ROW_W-1:0]   r_row_cnt;
    logic [ROW_W-1:0]   w_row_nxt;
    logic [7:0]         r_tile_idx;
    logic [7:0]         w_tile_nxt;
    logic               r_clear;
    logic               r_last;
    logic               w_we_a;
    logic               w_we_b;

    // Handshake outputs decode state only, so no combinational path from in_valid/out_ready.
    assign in_ready  = (r_state != PRESENT);
    assign out_valid = (r_state == PRESENT);
    assign tile_idx  = r_tile_idx;
    assign out_clear = r_clear;
    assign out_last  = r_last;

    always_comb begin
        w_state_nxt = r_state;
        w_row_nxt   = r_row_cnt;
        w_tile_nxt  = r_tile_idx;
        w_we_a      = 1'b0;
        w_we_b      = 1'b0;

        if (flush) begin
            w_state_nxt = LOAD_A;
            w_row_nxt   = '0;
            w_tile_nxt  = 8'd0;
        end else begin
            case (r_state)
                LOAD_A: begin
                    if (in_valid) begin
                        w_we_a = 1'b1;
                        if (r_row_cnt == C_ROW_LAST) begin
                            w_row_nxt   = '0;
                            w_state_nxt = LOAD_B;
                        end else begin
                            w_row_nxt = r_row_cnt + ROW_W'(1);
                        end
                    end
                end
                LOAD_B: begin
                    if (in_valid) begin
                        w_we_b = 1'b1;
                        if (r_row_cnt == C_ROW_LAST) begin
                            w_row_nxt   = '0;
                            w_state_nxt = PRESENT;
                        end else begin
                            w_row_nxt = r_row_cnt + ROW_W'(1);
                        end
                    end
                end
                PRESENT: begin
                    if (out_ready) begin
                        w_state_nxt = LOAD_A;
                        w_tile_nxt  = (r_tile_idx == C_TILE_LAST) ? 8'd0 : r_tile_idx + 8'd1;
                    end
                end
                default: begin
                    w_state_nxt = LOAD_A;
                    w_row_nxt   = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state    <= LOAD_A;
            r_row_cnt  <= '0;
            r_tile_idx <= 8'd0;
            r_clear    <= 1'b1;
            r_last     <= (K_TILES == 1);
        end else begin
            r_state    <= w_state_nxt;
            r_row_cnt  <= w_row_nxt;
            r_tile_idx <= w_tile_nxt;
            // Framing flags track the index so they stay stable while a pair is stalled.
            r_clear    <= (w_tile_nxt == 8'd0);
            r_last     <= (w_tile_nxt == C_TILE_LAST);
        end
    end

    mmac_tile_reg #(
        .N      (N),
        .ELEM_W (ELEM_W),
        .ROW_W  (ROW_W)
    ) u_tile_a (
        .clk (clk),
        .rst (rst),
        .we  (w_we_a),
        .row (r_row_cnt),
        .din (in_data),
        .q   (matrix_a)
    );

    mmac_tile_reg #(
        .N      (N),
        .ELEM_W (ELEM_W),
        .ROW_W  (ROW_W)
    ) u_tile_b (
        .clk (clk),
        .rst (rst),
        .we  (w_we_b),
        .row (r_row_cnt),
        .din (in_data),
        .q   (matrix_b)
    );

endmodule
`default_nettype wire

// File: tb/tb_mmac_operand_loader.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | tb_mmac_operand_loader                                                |
// | Directed vectors for the operand loader (N=4, ELEM_W=8, K_TILES=4).   |
// | Revision: 1.0                                                         |
// +-----------------------------------------------------------------------+
module tb_mmac_operand_loader;

    logic         clk;
    logic         rst;
    logic         flush;
    logic         in_valid;
    logic         in_ready;
    logic [31:0]  in_data;
    logic         out_valid;
    logic         out_ready;
    logic [127:0] matrix_a;
    logic [127:0] matrix_b;
    logic         out_clear;
    logic         out_last;
    logic [7:0]   tile_idx;

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic [7:0][31:0] rows;
        logic [7:0]       exp_idx;
        logic             exp_clr;
        logic             exp_last;
    } vec_t;

    vec_t vecs[5];

    mmac_operand_loader #(
        .N       (4),
        .ELEM_W  (8),
        .K_TILES (4)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .matrix_a  (matrix_a),
        .matrix_b  (matrix_b),
        .out_clear (out_clear),
        .out_last  (out_last),
        .tile_idx  (tile_idx)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Element [r][c] lands at bit (r*4+c)*8; row r element c comes from bits c*8 of that row.
    function automatic logic [127:0] pack_tile(input logic [3:0][31:0] rows);
        logic [127:0] m;
        m = '0;
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++)
                m[(r*4+c)*8 +: 8] = rows[r][c*8 +: 8];
        return m;
    endfunction

    function automatic logic [7:0][31:0] mk_rows(input int seed);
        logic [7:0][31:0] rr;
        for (int k = 0; k < 8; k++)
            for (int c = 0; c < 4; c++)
                rr[k][c*8 +: 8] = 8'(seed * 32 + k * 4 + c);
        return rr;
    endfunction

    // Called at a negedge; returns at the negedge after the beat was accepted.
    task automatic send_beat(input logic [31:0] d);
        int n;
        n = 0;
        in_valid = 1'b1;
        in_data  = d;
        while (!in_ready && n < 64) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready) begin
            total++;
            bad++;
            $display("FAIL beat_timeout: in_ready stayed 0 for %0d cycles, required 1", n);
        end
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic send_tile(input logic [7:0][31:0] rows);
        for (int k = 0; k < 8; k++) send_beat(rows[k]);
    endtask

    task automatic take_pair(input string tag, input logic [127:0] ea, input logic [127:0] eb,
                             input logic [7:0] eidx, input logic eclr, input logic elast);
        int n;
        n = 0;
        while (!out_valid && n < 64) begin
            @(negedge clk);
            n++;
        end
        chk({tag, "_valid"}, 128'(out_valid), 128'(1));
        chk({tag, "_in_ready"}, 128'(in_ready), 128'(0));
        chk({tag, "_a"}, matrix_a, ea);
        chk({tag, "_b"}, matrix_b, eb);
        chk({tag, "_idx"}, 128'(tile_idx), 128'(eidx));
        chk({tag, "_clear"}, 128'(out_clear), 128'(eclr));
        chk({tag, "_last"}, 128'(out_last), 128'(elast));
        out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        out_ready = 1'b0;
        chk({tag, "_done"}, 128'(out_valid), 128'(0));
    endtask

    initial begin
        logic [7:0][31:0] t_rows;
        logic [127:0]     ea;
        logic [127:0]     eb;
        int               e_idx[5]  = '{1, 2, 3, 0, 1};
        bit               e_clr[5]  = '{0, 0, 0, 1, 0};
        bit               e_last[5] = '{0, 0, 1, 0, 0};

        for (int i = 0; i < 5; i++) begin
            vecs[i].rows     = mk_rows(i + 2);
            vecs[i].exp_idx  = 8'(e_idx[i]);
            vecs[i].exp_clr  = e_clr[i];
            vecs[i].exp_last = e_last[i];
        end

        rst = 1'b0; flush = 1'b0; in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_out_valid", 128'(out_valid), 128'(0));
        chk("rst_in_ready", 128'(in_ready), 128'(1));
        chk("rst_tile_idx", 128'(tile_idx), 128'(0));
        chk("rst_matrix_a", matrix_a, 128'(0));
        chk("rst_matrix_b", matrix_b, 128'(0));
        rst = 1'b1;
        @(negedge clk);

        // Basic tile with out_ready held high.
        out_ready = 1'b1;
        send_beat(32'h03020100); send_beat(32'h07060504);
        send_beat(32'h0B0A0908); send_beat(32'h0F0E0D0C);
        send_beat(32'h13121110); send_beat(32'h17161514);
        send_beat(32'h1B1A1918); send_beat(32'h1F1E1D1C);
        chk("t1_valid", 128'(out_valid), 128'(1));
        chk("t1_in_ready", 128'(in_ready), 128'(0));
        chk("t1_a", matrix_a, 128'h0F0E0D0C_0B0A0908_07060504_03020100);
        chk("t1_b", matrix_b, 128'h1F1E1D1C_1B1A1918_17161514_13121110);
        chk("t1_clear", 128'(out_clear), 128'(1));
        chk("t1_last", 128'(out_last), 128'(0));
        chk("t1_idx", 128'(tile_idx), 128'(0));
        @(negedge clk);
        out_ready = 1'b0;
        chk("t1_pulse", 128'(out_valid), 128'(0));
        chk("t1_idx_next", 128'(tile_idx), 128'(1));

        // Back-to-back tiles through the group wrap.
        for (int i = 0; i < 5; i++) begin
            send_tile(vecs[i].rows);
            take_pair($sformatf("vec%0d", i), pack_tile(vecs[i].rows[3:0]), pack_tile(vecs[i].rows[7:4]),
                      vecs[i].exp_idx, vecs[i].exp_clr, vecs[i].exp_last);
        end

        // Stall in PRESENT with a beat pending.
        t_rows = mk_rows(7);
        ea = pack_tile(t_rows[3:0]);
        eb = pack_tile(t_rows[7:4]);
        send_tile(t_rows);
        in_valid = 1'b1;
        in_data  = 32'hDEADBEEF;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            chk("stall_in_ready", 128'(in_ready), 128'(0));
            chk("stall_hold", {matrix_a[63:0] ^ matrix_b[127:64], 62'd0, out_clear, out_last, out_valid},
                {ea[63:0] ^ eb[127:64], 62'd0, 1'b0, 1'b0, 1'b1});
        end
        in_valid = 1'b0;
        take_pair("stall", ea, eb, 8'd2, 1'b0, 1'b0);

        // Flush after three A beats of a tile.
        send_beat(32'hAAAA0000); send_beat(32'hAAAA1111); send_beat(32'hAAAA2222);
        flush = 1'b1;
        @(posedge clk);
        @(negedge clk);
        flush = 1'b0;
        chk("flush_idx", 128'(tile_idx), 128'(0));
        chk("flush_in_ready", 128'(in_ready), 128'(1));
        t_rows = mk_rows(5);
        send_tile(t_rows);
        take_pair("flush", pack_tile(t_rows[3:0]), pack_tile(t_rows[7:4]), 8'd0, 1'b1, 1'b0);

        // Flush coinciding with an output transfer.
        t_rows = mk_rows(6);
        send_tile(t_rows);
        chk("fx_valid", 128'(out_valid), 128'(1));
        out_ready = 1'b1;
        flush = 1'b1;
        @(posedge clk);
        @(negedge clk);
        flush = 1'b0;
        out_ready = 1'b0;
        chk("fx_idx", 128'(tile_idx), 128'(0));
        chk("fx_valid_low", 128'(out_valid), 128'(0));
        chk("fx_in_ready", 128'(in_ready), 128'(1));
        t_rows = mk_rows(3);
        send_tile(t_rows);
        take_pair("fx", pack_tile(t_rows[3:0]), pack_tile(t_rows[7:4]), 8'd0, 1'b1, 1'b0);

        // Asynchronous reset pulse in the middle of LOAD_B.
        t_rows = mk_rows(4);
        for (int k = 0; k < 6; k++) send_beat(t_rows[k]);
        #2 rst = 1'b0;
        #1;
        chk("arst_valid", 128'(out_valid), 128'(0));
        chk("arst_in_ready", 128'(in_ready), 128'(1));
        chk("arst_a", matrix_a, 128'(0));
        chk("arst_b", matrix_b, 128'(0));
        rst = 1'b1;
        @(negedge clk);
        t_rows = mk_rows(1);
        send_tile(t_rows);
        take_pair("arst", pack_tile(t_rows[3:0]), pack_tile(t_rows[7:4]), 8'd0, 1'b1, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
